// File: rtl/cpstr_man_rx_pkg.sv
// Shared cpstr constants: escape byte, decoder state encoding, index width helper.
// The TX escaper imports the same values so both directions agree on framing.
package cpstr_man_rx_pkg;

    localparam logic [7:0] CPSTR_ESC_CHAR = 8'h5A;

    typedef enum logic {
        S_DATA = 1'b0,
        S_ESC  = 1'b1
    } cpstr_state_e;

    // Index width for the one-hot decode; never narrower than one bit.
    function automatic int cpstr_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpstr_unesc.sv
// Escape decoder: splits an escaped byte stream into plain data bytes and
// escaped index bytes. Inverse of cpstr_esc; consumes a byte only when i_ready.
module cpstr_unesc
    import cpstr_man_rx_pkg::*;
#(
    parameter logic [7:0] ESC_CHAR = CPSTR_ESC_CHAR
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic [7:0] o_esc_data,
    output logic       o_esc_valid,
    input  logic       i_ready
);

    cpstr_state_e state_q, state_d;
    logic         is_esc;
    logic         take;

    assign is_esc     = (i_data == ESC_CHAR);
    assign take       = i_valid && i_ready;
    assign o_ready    = i_ready;
    assign o_data     = i_data;
    assign o_esc_data = i_data;

    always_comb begin
        state_d     = state_q;
        o_valid     = 1'b0;
        o_esc_valid = 1'b0;
        case (state_q)
            S_DATA: begin
                if (is_esc) begin
                    if (take) state_d = S_ESC;
                end else begin
                    o_valid = i_valid;
                end
            end
            S_ESC: begin
                // ESC,ESC is a literal; anything else after ESC is an index.
                o_valid     = i_valid && is_esc;
                o_esc_valid = i_valid && !is_esc;
                if (take) state_d = S_DATA;
            end
            default: state_d = S_DATA;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_DATA;
        else       state_q <= state_d;
    end

endmodule

// File: rtl/cpstr_man_rx.sv
// Receive-side stream demultiplexer: decodes {ESC_CHAR, idx} framing and routes
// data bytes through a single-entry output register to one of NUM_STREAMS outputs.
module cpstr_man_rx
    import cpstr_man_rx_pkg::*;
#(
    parameter int         NUM_STREAMS = 2,
    parameter logic [7:0] ESC_CHAR    = CPSTR_ESC_CHAR
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [7:0]                 i_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [8*NUM_STREAMS-1:0]   o_data,
    output logic [NUM_STREAMS-1:0]     o_valid,
    input  logic [NUM_STREAMS-1:0]     i_ready,
    output logic [7:0]                 o_stridx,
    output logic                       o_stridx_valid,
    output logic                       o_err,
    output logic                       o_drop
);

    localparam int         IDX_W = cpstr_idx_w(NUM_STREAMS);
    localparam logic [7:0] NS8   = 8'(NUM_STREAMS);

    logic [7:0]             dat_b, esc_b;
    logic                   dat_v, esc_v;
    logic                   rdy, drain, idx_ok;

    logic                   full_q, full_d;
    logic [7:0]             data_q, data_d;
    logic [NUM_STREAMS-1:0] dest_q, dest_d;
    logic [7:0]             stridx_q, stridx_d;
    logic                   stridx_valid_q, stridx_valid_d;
    logic                   err_q, err_d;
    logic                   drop_q, drop_d;

    // Ready never looks at i_valid, only at the held byte's own destination.
    assign drain = full_q && ((dest_q & i_ready) != '0);
    assign rdy   = !full_q || drain;

    cpstr_unesc #(
        .ESC_CHAR(ESC_CHAR)
    ) u_unesc (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_data     (dat_b),
        .o_valid    (dat_v),
        .o_esc_data (esc_b),
        .o_esc_valid(esc_v),
        .i_ready    (rdy)
    );

    assign idx_ok = (esc_b < NS8);

    always_comb begin
        full_d         = full_q;
        data_d         = data_q;
        dest_d         = dest_q;
        stridx_d       = stridx_q;
        stridx_valid_d = stridx_valid_q;
        err_d          = 1'b0;
        drop_d         = 1'b0;

        if (drain) full_d = 1'b0;

        if (rdy && esc_v) begin
            stridx_d       = esc_b;
            stridx_valid_d = idx_ok;
            err_d          = !idx_ok;
        end

        // Routing uses the index registered before this byte, so a switch
        // never retargets a byte already held or accepted in the same cycle.
        if (rdy && dat_v) begin
            if (stridx_valid_q) begin
                data_d = dat_b;
                dest_d = NUM_STREAMS'(1) << stridx_q[IDX_W-1:0];
                full_d = 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            full_q         <= 1'b0;
            data_q         <= '0;
            dest_q         <= '0;
            stridx_q       <= '0;
            stridx_valid_q <= 1'b0;
            err_q          <= 1'b0;
            drop_q         <= 1'b0;
        end else begin
            full_q         <= full_d;
            data_q         <= data_d;
            dest_q         <= dest_d;
            stridx_q       <= stridx_d;
            stridx_valid_q <= stridx_valid_d;
            err_q          <= err_d;
            drop_q         <= drop_d;
        end
    end

    for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_lane
        assign o_data[8*g +: 8] = data_q;
    end

    assign o_valid        = full_q ? dest_q : '0;
    assign o_stridx       = stridx_q;
    assign o_stridx_valid = stridx_valid_q;
    assign o_err          = err_q;
    assign o_drop         = drop_q;

endmodule

// File: tb/tb_cpstr_man_rx.sv
// Directed table-driven bench for cpstr_man_rx with NUM_STREAMS=2, plus
// hand-written sequences for pulse trains and a long-pending escape.
module tb_cpstr_man_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] o_data;
    logic [1:0]  o_valid;
    logic [1:0]  i_ready;
    logic [7:0]  o_stridx;
    logic        o_stridx_valid;
    logic        o_err;
    logic        o_drop;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpstr_man_rx #(.NUM_STREAMS(2), .ESC_CHAR(8'h5A)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_stridx      (o_stridx),
        .o_stridx_valid(o_stridx_valid),
        .o_err         (o_err),
        .o_drop        (o_drop)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] din;
        logic [1:0] rdy;
        logic       ordy;
        logic [1:0] ovld;
        logic [7:0] od;
        logic [7:0] idx;
        logic       idxv;
        logic       err;
        logic       drop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int r, v, d, rd, ordy, ovld, od, idx, idxv, e, dp);
        vec_t t;
        t.rst = 1'(r); t.vld = 1'(v); t.din = 8'(d); t.rdy = 2'(rd);
        t.ordy = 1'(ordy); t.ovld = 2'(ovld); t.od = 8'(od); t.idx = 8'(idx);
        t.idxv = 1'(idxv); t.err = 1'(e); t.drop = 1'(dp);
        return t;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic [1:0] rd);
        @(posedge clk);
        #1;
        rst = r; i_valid = v; i_data = d; i_ready = rd;
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_data = 8'h00; i_ready = 2'b11;

        //          rst vld din   rdy  ordy ovld od    idx idxv err drop
        tbl.push_back(mk(1, 0, 'h00, 3, 1, 0, 'h00, 0, 0, 0, 0));
        // select stream 1, send 11 22
        tbl.push_back(mk(0, 1, 'h5A, 3, 1, 0, 'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h01, 3, 1, 0, 'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h11, 3, 1, 0, 'h00, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'h22, 3, 1, 2, 'h11, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 'h00, 3, 1, 2, 'h22, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 'h00, 3, 1, 0, 'h22, 1, 1, 0, 0));
        // literal escape on stream 0
        tbl.push_back(mk(0, 1, 'h5A, 3, 1, 0, 'h22, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'h00, 3, 1, 0, 'h22, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'h5A, 3, 1, 0, 'h22, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'h5A, 3, 1, 0, 'h22, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'h33, 3, 1, 1, 'h5A, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 'h00, 3, 1, 1, 'h33, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 'h00, 3, 1, 0, 'h33, 0, 1, 0, 0));
        // stall on stream 0
        tbl.push_back(mk(0, 1, 'h5A, 2, 1, 0, 'h33, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'h00, 2, 1, 0, 'h33, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'hAA, 2, 1, 0, 'h33, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'hBB, 2, 0, 1, 'hAA, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'hBB, 2, 0, 1, 'hAA, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'hBB, 2, 0, 1, 'hAA, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'hBB, 3, 1, 1, 'hAA, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 'h00, 3, 1, 1, 'hBB, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 'h00, 3, 1, 0, 'hBB, 0, 1, 0, 0));
        // switch stream while AA held for stream 0
        tbl.push_back(mk(0, 1, 'h5A, 2, 1, 0, 'hBB, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'h00, 2, 1, 0, 'hBB, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'hAA, 2, 1, 0, 'hBB, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'h5A, 2, 0, 1, 'hAA, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'h5A, 1, 1, 1, 'hAA, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'h01, 1, 1, 0, 'hAA, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'hBB, 1, 1, 0, 'hAA, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 'h00, 1, 0, 2, 'hBB, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 'h00, 3, 1, 2, 'hBB, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 'h00, 3, 1, 0, 'hBB, 1, 1, 0, 0));
        // bad index 07, drops, then recover on stream 1
        tbl.push_back(mk(0, 1, 'h5A, 3, 1, 0, 'hBB, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'h07, 3, 1, 0, 'hBB, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'hCC, 3, 1, 0, 'hBB, 7, 0, 1, 0));
        tbl.push_back(mk(0, 1, 'hDD, 3, 1, 0, 'hBB, 7, 0, 0, 1));
        tbl.push_back(mk(0, 1, 'h5A, 3, 1, 0, 'hBB, 7, 0, 0, 1));
        tbl.push_back(mk(0, 1, 'h01, 3, 1, 0, 'hBB, 7, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'hEE, 3, 1, 0, 'hBB, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 'h00, 3, 1, 2, 'hEE, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 'h00, 3, 1, 0, 'hEE, 1, 1, 0, 0));
        // reset while a stalled byte is held
        tbl.push_back(mk(0, 1, 'hFF, 1, 1, 0, 'hEE, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 'h00, 1, 0, 2, 'hFF, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 'h00, 1, 1, 0, 'h00, 0, 0, 0, 0));
        // reset while an ESC is pending: following 01 is data and dropped
        tbl.push_back(mk(0, 1, 'h5A, 3, 1, 0, 'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h01, 3, 1, 0, 'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h5A, 3, 1, 0, 'h00, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 'h00, 3, 1, 0, 'h00, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'h01, 3, 1, 0, 'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 'h00, 3, 1, 0, 'h00, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 'h00, 3, 1, 0, 'h00, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].din, tbl[i].rdy);
            @(negedge clk);
            chk("o_ready",        i, 32'(o_ready),        32'(tbl[i].ordy));
            chk("o_valid",        i, 32'(o_valid),        32'(tbl[i].ovld));
            chk("o_data",         i, 32'(o_data),         32'({tbl[i].od, tbl[i].od}));
            chk("o_stridx",       i, 32'(o_stridx),       32'(tbl[i].idx));
            chk("o_stridx_valid", i, 32'(o_stridx_valid), 32'(tbl[i].idxv));
            chk("o_err",          i, 32'(o_err),          32'(tbl[i].err));
            chk("o_drop",         i, 32'(o_drop),         32'(tbl[i].drop));
        end

        // back-to-back drops with no stream selected give back-to-back pulses
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, (k < 3), 8'(8'h10 + 8'(k)), 2'b11);
            @(negedge clk);
            chk("drop_train", k, 32'(o_drop), 32'((k >= 1 && k <= 3) ? 1 : 0));
        end

        // an ESC followed by a long idle still treats the next byte as an index
        drive(1'b0, 1'b1, 8'h5A, 2'b11);
        for (int k = 0; k < 20; k++) drive(1'b0, 1'b0, 8'h00, 2'b11);
        @(negedge clk);
        chk("esc_idle_idxv", 0, 32'(o_stridx_valid), 32'(0));
        drive(1'b0, 1'b1, 8'h00, 2'b11);
        drive(1'b0, 1'b1, 8'h77, 2'b01);
        @(negedge clk);
        chk("esc_idle_idx",  1, 32'(o_stridx),       32'(0));
        chk("esc_idle_idxv", 1, 32'(o_stridx_valid), 32'(1));
        chk("esc_idle_err",  1, 32'(o_err),          32'(0));
        drive(1'b0, 1'b0, 8'h00, 2'b01);
        begin
            bit got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge clk);
                if (o_valid != 2'b00) got = 1'b1;
            end
            chk("esc_idle_seen",  2, 32'(got),           32'(1));
            chk("esc_idle_valid", 2, 32'(o_valid),       32'(2'b01));
            chk("esc_idle_data",  2, 32'(o_data),        32'(16'h7777));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
